// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Purpose : architectural address type shared by front-end blocks.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int unsigned VLEN = 32;

    typedef logic [VLEN-1:0] addr_t;

endpackage : riscv_pkg

// File: rtl/tortoise_pkg.sv
// -----------------------------------------------------------------------------
// tortoise_pkg
// Purpose : predictor-side types: instruction class, branch update payload and
//           the default depth of the branch update queue.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package tortoise_pkg;

    import riscv_pkg::*;

    localparam int unsigned BRANCH_UPDATE_DEPTH = 8;

    typedef enum logic [1:0] {
        NO_BRANCH      = 2'd0,
        PREDICT_TAKEN  = 2'd1,
        DIRECT_JUMP    = 2'd2,
        PREDICT_TARGET = 2'd3
    } predict_t;

    // One resolved outcome destined for the BHT/BTB update port.
    typedef struct packed {
        addr_t    pc;
        addr_t    target;
        logic     taken;
        predict_t btype;
    } branch_update_t;

    // Only classes that train a predictor table are worth queueing.
    function automatic logic needs_table_update(input predict_t t);
        return (t == PREDICT_TAKEN) || (t == PREDICT_TARGET);
    endfunction

endpackage : tortoise_pkg

// File: rtl/branch_update_fifo.sv
// -----------------------------------------------------------------------------
// branch_update_fifo
// Purpose : multi-write / single-read circular buffer of branch updates.
//           Writes arrive pre-compacted: slot k lands at wptr+k.
// Ports   : clk_i, rst_i (sync, active-high), clr_i (flush),
//           wr_en_i/wr_data_i (NR_WR compacted writes), pop_i,
//           head_c (entry at rptr), free_c (slots usable this cycle,
//           counting a same-cycle pop), count_o, full_o (registered).
//           With BRANCH_UPDATE_COALESCE_EN: upd_en_i/upd_target_i/upd_taken_i
//           rewrite the newest entry, tail_c exposes it.
// -----------------------------------------------------------------------------
module branch_update_fifo
    import tortoise_pkg::*;
#(
    parameter int unsigned DEPTH = BRANCH_UPDATE_DEPTH,
    parameter int unsigned NR_WR = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clr_i,
    input  logic [NR_WR-1:0]            wr_en_i,
    input  branch_update_t [NR_WR-1:0]  wr_data_i,
    input  logic                        pop_i,
`ifdef BRANCH_UPDATE_COALESCE_EN
    input  logic                        upd_en_i,
    input  riscv_pkg::addr_t            upd_target_i,
    input  logic                        upd_taken_i,
    output branch_update_t              tail_c,
`endif
    output branch_update_t              head_c,
    output logic [CNT_W-1:0]            free_c,
    output logic [CNT_W-1:0]            count_o,
    output logic                        full_o
);

    branch_update_t   mem_q [DEPTH];
    branch_update_t   mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] n_push;
    logic             full_q, full_d;

    assign head_c  = mem_q[rptr_q];
    assign free_c  = CNT_W'(DEPTH) - count_q + CNT_W'(pop_i);
    assign count_o = count_q;
    assign full_o  = full_q;
`ifdef BRANCH_UPDATE_COALESCE_EN
    assign tail_c  = mem_q[wptr_q - PTR_W'(1)];
`endif

    // Next pointers, count and storage contents.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        n_push  = '0;
        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
`ifdef BRANCH_UPDATE_COALESCE_EN
            if (upd_en_i) begin
                mem_d[wptr_q - PTR_W'(1)].target = upd_target_i;
                mem_d[wptr_q - PTR_W'(1)].taken  = upd_taken_i;
            end
`endif
            for (int unsigned k = 0; k < NR_WR; k++) begin
                if (wr_en_i[k]) begin
                    mem_d[wptr_q + PTR_W'(k)] = wr_data_i[k];
                    n_push = n_push + CNT_W'(1);
                end
            end
            wptr_d = wptr_q + PTR_W'(n_push);
            if (pop_i) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            count_d = count_q + n_push - CNT_W'(pop_i);
        end
        full_d = (count_d == CNT_W'(DEPTH));
    end

    // Valid tracking is reset; entry storage is not.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule : branch_update_fifo

// File: rtl/branch_update_arbiter.sv
// -----------------------------------------------------------------------------
// branch_update_arbiter
// Purpose : funnels resolved branch outcomes from NR_COMMIT commit ports into
//           the single predictor fallback update port (fb_*), one per cycle,
//           through a circular queue. Outcomes that train no table are dropped
//           at the door.
// Ports   : clk_i, rst_i (sync, active-high), flush_i, debug_mode_i,
//           cm_valid_i/cm_pc_i/cm_target_i/cm_taken_i/cm_type_i (per port),
//           fb_valid_o/fb_branch_pc_o/fb_target_addr_o/fb_branch_taken_o/
//           fb_type_o (registered update), full_o (registered),
//           drop_o (combinational: an eligible outcome found no slot).
// Config  : `define BRANCH_UPDATE_COALESCE_EN merges an input matching the
//           newest queued entry (pc and type) into that entry.
// -----------------------------------------------------------------------------
module branch_update_arbiter
    import riscv_pkg::*;
    import tortoise_pkg::*;
#(
    parameter int unsigned NR_COMMIT = 2,
    parameter int unsigned DEPTH     = BRANCH_UPDATE_DEPTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      debug_mode_i,
    input  logic [NR_COMMIT-1:0]      cm_valid_i,
    input  addr_t [NR_COMMIT-1:0]     cm_pc_i,
    input  addr_t [NR_COMMIT-1:0]     cm_target_i,
    input  logic [NR_COMMIT-1:0]      cm_taken_i,
    input  predict_t [NR_COMMIT-1:0]  cm_type_i,
    output logic                      fb_valid_o,
    output addr_t                     fb_branch_pc_o,
    output addr_t                     fb_target_addr_o,
    output logic                      fb_branch_taken_o,
    output predict_t                  fb_type_o,
    output logic                      full_o,
    output logic                      drop_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned SLOT_W = (NR_COMMIT > 1) ? $clog2(NR_COMMIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e                        state_q, state_d;
    logic                          fb_valid_q, fb_valid_d;
    addr_t                         fb_pc_q, fb_pc_d;
    addr_t                         fb_target_q, fb_target_d;
    logic                          fb_taken_q, fb_taken_d;
    predict_t                      fb_type_q, fb_type_d;

    logic                          pop_c;
    logic                          drop_c;
    logic [NR_COMMIT-1:0]          wr_en_c;
    branch_update_t [NR_COMMIT-1:0] wr_data_c;
    logic [CNT_W-1:0]              slot_c;
    logic [CNT_W-1:0]              count_next_c;
    logic                          elig_c;

    branch_update_t                head_c;
    logic [CNT_W-1:0]              free_c;
    logic [CNT_W-1:0]              count_q;
    logic                          full_q;

`ifdef BRANCH_UPDATE_COALESCE_EN
    branch_update_t                tail_c;
    logic                          tail_ok_c;
    logic                          upd_en_c;
    addr_t                         upd_target_c;
    logic                          upd_taken_c;
`endif

    branch_update_fifo #(
        .DEPTH (DEPTH),
        .NR_WR (NR_COMMIT)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (flush_i),
        .wr_en_i      (wr_en_c),
        .wr_data_i    (wr_data_c),
        .pop_i        (pop_c),
`ifdef BRANCH_UPDATE_COALESCE_EN
        .upd_en_i     (upd_en_c),
        .upd_target_i (upd_target_c),
        .upd_taken_i  (upd_taken_c),
        .tail_c       (tail_c),
`endif
        .head_c       (head_c),
        .free_c       (free_c),
        .count_o      (count_q),
        .full_o       (full_q)
    );

    // Eligibility filter, slot compaction, drain decision and next state.
    always_comb begin
        state_d      = state_q;
        fb_valid_d   = 1'b0;
        fb_pc_d      = fb_pc_q;
        fb_target_d  = fb_target_q;
        fb_taken_d   = fb_taken_q;
        fb_type_d    = fb_type_q;
        pop_c        = 1'b0;
        drop_c       = 1'b0;
        wr_en_c      = '0;
        wr_data_c    = '0;
        slot_c       = '0;
        count_next_c = count_q;
        elig_c       = 1'b0;
`ifdef BRANCH_UPDATE_COALESCE_EN
        tail_ok_c    = 1'b0;
        upd_en_c     = 1'b0;
        upd_target_c = '0;
        upd_taken_c  = 1'b0;
`endif
        if (flush_i) begin
            state_d = FLUSH;
        end else begin
            pop_c = (state_q != FLUSH) && (count_q != '0);
            if (pop_c) begin
                fb_valid_d  = 1'b1;
                fb_pc_d     = head_c.pc;
                fb_target_d = head_c.target;
                fb_taken_d  = head_c.taken;
                fb_type_d   = head_c.btype;
            end
`ifdef BRANCH_UPDATE_COALESCE_EN
            // The newest entry is off-limits while it is leaving this cycle.
            tail_ok_c = (count_q != '0) && !((count_q == CNT_W'(1)) && pop_c);
`endif
            for (int unsigned i = 0; i < NR_COMMIT; i++) begin
                elig_c = cm_valid_i[i] && !debug_mode_i && needs_table_update(cm_type_i[i]);
`ifdef BRANCH_UPDATE_COALESCE_EN
                // Matches are against the pre-cycle tail; a later port wins.
                if (elig_c && tail_ok_c && (cm_pc_i[i] == tail_c.pc)
                        && (cm_type_i[i] == tail_c.btype)) begin
                    upd_en_c     = 1'b1;
                    upd_target_c = cm_target_i[i];
                    upd_taken_c  = cm_taken_i[i];
                    elig_c       = 1'b0;
                end
`endif
                if (elig_c) begin
                    if (slot_c < free_c) begin
                        wr_en_c[SLOT_W'(slot_c)]        = 1'b1;
                        wr_data_c[SLOT_W'(slot_c)].pc     = cm_pc_i[i];
                        wr_data_c[SLOT_W'(slot_c)].target = cm_target_i[i];
                        wr_data_c[SLOT_W'(slot_c)].taken  = cm_taken_i[i];
                        wr_data_c[SLOT_W'(slot_c)].btype  = cm_type_i[i];
                        slot_c = slot_c + CNT_W'(1);
                    end else begin
                        drop_c = 1'b1;
                    end
                end
            end
            count_next_c = count_q - CNT_W'(pop_c) + slot_c;
            state_d      = (count_next_c != '0) ? DRAIN : IDLE;
        end
    end

    // State and registered update port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            fb_valid_q  <= 1'b0;
            fb_pc_q     <= '0;
            fb_target_q <= '0;
            fb_taken_q  <= 1'b0;
            fb_type_q   <= NO_BRANCH;
        end else begin
            state_q     <= state_d;
            fb_valid_q  <= fb_valid_d;
            fb_pc_q     <= fb_pc_d;
            fb_target_q <= fb_target_d;
            fb_taken_q  <= fb_taken_d;
            fb_type_q   <= fb_type_d;
        end
    end

    assign fb_valid_o        = fb_valid_q;
    assign fb_branch_pc_o    = fb_pc_q;
    assign fb_target_addr_o  = fb_target_q;
    assign fb_branch_taken_o = fb_taken_q;
    assign fb_type_o         = fb_type_q;
    assign full_o            = full_q;
    assign drop_o            = drop_c;

endmodule : branch_update_arbiter

// File: tb/tb_branch_update_arbiter.sv
// -----------------------------------------------------------------------------
// tb_branch_update_arbiter
// Purpose : self-checking bench for branch_update_arbiter. A queue-based
//           reference model predicts every fb_* pulse, full_o and drop_o.
// -----------------------------------------------------------------------------
module tb_branch_update_arbiter;

    import riscv_pkg::*;
    import tortoise_pkg::*;

    localparam int unsigned NRC = 2;
    localparam int unsigned DEP = BRANCH_UPDATE_DEPTH;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                flush = 1'b0;
    logic                dbg = 1'b0;
    logic [NRC-1:0]      cm_valid = '0;
    addr_t [NRC-1:0]     cm_pc = '0;
    addr_t [NRC-1:0]     cm_target = '0;
    logic [NRC-1:0]      cm_taken = '0;
    predict_t [NRC-1:0]  cm_type = {NO_BRANCH, NO_BRANCH};

    logic                fb_valid;
    addr_t               fb_pc;
    addr_t               fb_target;
    logic                fb_taken;
    predict_t            fb_type;
    logic                full;
    logic                drop;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned pulses_dut = 0;
    int unsigned pulses_exp = 0;

    branch_update_t mq[$];
    branch_update_t exp_fb;
    logic           exp_valid;

    always #5 clk = ~clk;

    branch_update_arbiter #(.NR_COMMIT(NRC), .DEPTH(DEP)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_i           (flush),
        .debug_mode_i      (dbg),
        .cm_valid_i        (cm_valid),
        .cm_pc_i           (cm_pc),
        .cm_target_i       (cm_target),
        .cm_taken_i        (cm_taken),
        .cm_type_i         (cm_type),
        .fb_valid_o        (fb_valid),
        .fb_branch_pc_o    (fb_pc),
        .fb_target_addr_o  (fb_target),
        .fb_branch_taken_o (fb_taken),
        .fb_type_o         (fb_type),
        .full_o            (full),
        .drop_o            (drop)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_port(input int p, input logic v, input predict_t t,
                            input addr_t pc, input addr_t tgt, input logic tk);
        cm_valid[p]  = v;
        cm_type[p]   = t;
        cm_pc[p]     = pc;
        cm_target[p] = tgt;
        cm_taken[p]  = tk;
    endtask

    task automatic idle_inputs();
        cm_valid = '0;
        flush    = 1'b0;
        dbg      = 1'b0;
        rst      = 1'b0;
    endtask

    // One clock: model the edge from the spec's rules, check drop_o before it
    // and the registered outputs after it. Inputs are driven at negedge.
    task automatic step();
        logic           exp_drop;
        logic           tail_ok;
        int             tidx;
        branch_update_t tail;
        branch_update_t e;
        exp_drop = 1'b0;
        #1;
        if (rst) begin
            mq.delete();
            exp_valid = 1'b0;
            exp_fb    = '0;
        end else if (flush) begin
            mq.delete();
            exp_valid = 1'b0;
        end else begin
            exp_valid = (mq.size() > 0);
            if (exp_valid) exp_fb = mq.pop_front();
            tail_ok = (mq.size() > 0);
            tidx    = mq.size() - 1;
            tail    = tail_ok ? mq[tidx] : '0;
            for (int i = 0; i < NRC; i++) begin
                if (cm_valid[i] && !dbg &&
                    (cm_type[i] == PREDICT_TAKEN || cm_type[i] == PREDICT_TARGET)) begin
`ifdef BRANCH_UPDATE_COALESCE_EN
                    if (tail_ok && cm_pc[i] == tail.pc && cm_type[i] == tail.btype) begin
                        mq[tidx].target = cm_target[i];
                        mq[tidx].taken  = cm_taken[i];
                        continue;
                    end
`endif
                    if (mq.size() < DEP) begin
                        e.pc = cm_pc[i]; e.target = cm_target[i];
                        e.taken = cm_taken[i]; e.btype = cm_type[i];
                        mq.push_back(e);
                    end else begin
                        exp_drop = 1'b1;
                    end
                end
            end
            check_eq("drop_o", 64'(drop), 64'(exp_drop));
        end
        @(posedge clk);
        #1;
        if (exp_valid) pulses_exp++;
        if (fb_valid) pulses_dut++;
        check_eq("fb_valid_o", 64'(fb_valid), 64'(exp_valid));
        if (exp_valid || rst) begin
            check_eq("fb_branch_pc_o", 64'(fb_pc), 64'(exp_fb.pc));
            check_eq("fb_target_addr_o", 64'(fb_target), 64'(exp_fb.target));
            check_eq("fb_branch_taken_o", 64'(fb_taken), 64'(exp_fb.taken));
            check_eq("fb_type_o", 64'(fb_type), 64'(exp_fb.btype));
        end
        check_eq("full_o", 64'(full), 64'(mq.size() == DEP));
        @(negedge clk);
    endtask

    task automatic drain(input int max_cycles);
        idle_inputs();
        for (int c = 0; c < max_cycles; c++) begin
            if (mq.size() == 0 && !exp_valid) break;
            step();
        end
        check_eq("drained", 64'(mq.size()), 64'd0);
    endtask

    initial begin
        exp_fb    = '0;
        exp_valid = 1'b0;
        @(negedge clk);

        // Reset.
        rst = 1'b1;
        step();
        step();
        idle_inputs();

        // Single PREDICT_TAKEN on port 0: pulse two edges after enqueue.
        set_port(0, 1'b1, PREDICT_TAKEN, 32'h1000, 32'h1040, 1'b1);
        step();
        check_eq("lat_edge1_valid", 64'(fb_valid), 64'd0);
        idle_inputs();
        step();
        check_eq("lat_edge2_pc", 64'(fb_valid ? fb_pc : 32'h0), 64'h1000);
        drain(4);
        check_eq("pulses_single", 64'(pulses_dut), 64'(pulses_exp));

        // Two eligible ports in one cycle: drained in port order.
        set_port(0, 1'b1, PREDICT_TARGET, 32'h2000, 32'h3000, 1'b1);
        set_port(1, 1'b1, PREDICT_TAKEN,  32'h2004, 32'h2100, 1'b0);
        step();
        drain(6);

        // Non-updating classes are filtered.
        set_port(0, 1'b1, DIRECT_JUMP, 32'h5000, 32'h6000, 1'b1);
        set_port(1, 1'b1, NO_BRANCH,   32'h5004, 32'h0,    1'b0);
        step();
        check_eq("filter_drop", 64'(drop), 64'd0);
        drain(3);

        // Fill to DEPTH, then two inputs against one freed slot.
        begin
            int unsigned base;
            base = pulses_dut;
            for (int c = 0; c < 20 && mq.size() < DEP; c++) begin
                set_port(0, 1'b1, PREDICT_TAKEN, 32'h7000 + 32'(c * 8), 32'h0, 1'b1);
                set_port(1, 1'b1, PREDICT_TAKEN, 32'h7004 + 32'(c * 8), 32'h0, 1'b0);
                step();
            end
            set_port(0, 1'b1, PREDICT_TARGET, 32'h9000, 32'h9100, 1'b1);
            set_port(1, 1'b1, PREDICT_TARGET, 32'h9004, 32'h9200, 1'b1);
            #1;
            check_eq("full_drop_c", 64'(drop), 64'd1);
            step();
            drain(20);
            check_eq("pulses_fill", 64'(pulses_dut), 64'(pulses_exp));
            check_eq("pulses_fill_n", 64'(pulses_dut - base), 64'(pulses_exp - base));
        end

        // Flush with entries pending.
        for (int c = 0; c < 5; c++) begin
            set_port(0, 1'b1, PREDICT_TAKEN, 32'hA000 + 32'(c * 16), 32'h0, 1'b1);
            set_port(1, 1'b1, PREDICT_TAKEN, 32'hA004 + 32'(c * 16), 32'h0, 1'b1);
            step();
        end
        idle_inputs();
        flush = 1'b1;
        step();
        check_eq("flush_valid", 64'(fb_valid), 64'd0);
        idle_inputs();
        step();
        step();
        set_port(0, 1'b1, PREDICT_TARGET, 32'hB000, 32'hB800, 1'b0);
        step();
        drain(5);

        // Same pc/type on consecutive cycles behind an older entry.
        set_port(0, 1'b1, PREDICT_TAKEN, 32'h5000, 32'h0,    1'b1);
        set_port(1, 1'b1, PREDICT_TAKEN, 32'h4000, 32'h4100, 1'b0);
        step();
        idle_inputs();
        set_port(0, 1'b1, PREDICT_TAKEN, 32'h4000, 32'h4200, 1'b1);
        step();
        drain(6);
        check_eq("pulses_coalesce", 64'(pulses_dut), 64'(pulses_exp));

        // Randomized traffic, small pc pool so coalescing and fills occur.
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            rst   = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 39) == 0);
            dbg   = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < NRC; p++) begin
                addr_t pc;
                pc = ($urandom_range(0, 3) == 0) ? addr_t'($urandom) : 32'h100 + 32'($urandom_range(0, 2) * 4);
                set_port(p, 1'($urandom_range(0, 3) != 0), predict_t'($urandom_range(0, 3)),
                         pc, addr_t'($urandom), 1'($urandom));
            end
            step();
        end
        drain(20);
        check_eq("pulses_total", 64'(pulses_dut), 64'(pulses_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_branch_update_arbiter
